hack_multi_stream_loader: RTL and testbench

- Parametrised successor to the single-ROM stream loader in the hack_soc.
- Assembles DATA_WIDTH-bit words from IN_WIDTH-bit beats clocked in on an external sck, then writes them to one of NUM_TARGETS memories (e.g. ROM, RAM) at consecutive addresses from a programmable base.
- Adds sck synchronisation, overrun and wrap error reporting, per-load word count and per-target busy/initialised handshakes.

---
 rtl/hack_multi_stream_loader.sv | 157 +++++++++++++++
 tb/tb_hack_multi_stream_loader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_multi_stream_loader.sv
// Multi-target stream loader: synchronises an external sck/beat stream, assembles words and
// writes them to one of NUM_TARGETS memories. Optional running checksum under LOADER_CHECKSUM_EN.
module hack_multi_stream_loader #(
    parameter int DATA_WIDTH    = 16,
    parameter int IN_WIDTH      = 4,
    parameter int ADDRESS_WIDTH = 16,
    parameter int NUM_TARGETS   = 2,
    localparam int TSEL_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [TSEL_W-1:0]        target_sel,
    input  logic [ADDRESS_WIDTH-1:0] base_address,
    input  logic [IN_WIDTH-1:0]      input_data,
    input  logic                     sck,
    output logic                     ack,
    output logic                     error,
    output logic [ADDRESS_WIDTH-1:0] words_written,
    input  logic [NUM_TARGETS-1:0]   mem_busy,
    input  logic [NUM_TARGETS-1:0]   mem_initialized,
    output logic [NUM_TARGETS-1:0]   mem_request,
    output logic [DATA_WIDTH-1:0]    output_data,
    output logic [ADDRESS_WIDTH-1:0] output_address,
    output logic [DATA_WIDTH-1:0]    checksum
);
    localparam int BEATS = DATA_WIDTH / IN_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {IDLE, COLLECT, REQ, WRITE, HALT} state_t;
    state_t state, state_next;

    logic                  sck_s1, sck_s2, sck_prev, beat_edge, was_loading;
    logic [IN_WIDTH-1:0]   data_s1, data_s2, beat;
    logic [TSEL_W-1:0]     tgt;
    logic [CNT_W-1:0]      beat_cnt;
    logic [DATA_WIDTH-1:0] word, assembled;
    logic [DATA_WIDTH+IN_WIDTH-1:0] shifted;
    logic [NUM_TARGETS-1:0] tgt_mask;
    logic load_start, tgt_ok, word_done, granted, ready, write_done, at_top, start_ok, ack_now;

    // The detected edge and its beat are registered together so data and strobe stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_s1      <= 1'b0;
            sck_s2      <= 1'b0;
            sck_prev    <= 1'b0;
            beat_edge   <= 1'b0;
            data_s1     <= '0;
            data_s2     <= '0;
            beat        <= '0;
            was_loading <= 1'b0;
        end else begin
            sck_s1      <= sck;
            sck_s2      <= sck_s1;
            sck_prev    <= sck_s2;
            beat_edge   <= sck_s2 & ~sck_prev;
            data_s1     <= input_data;
            data_s2     <= data_s1;
            beat        <= data_s2;
            was_loading <= load;
        end
    end

    always_comb begin
        load_start = load & ~was_loading;
        tgt_ok     = int'({1'b0, target_sel}) < NUM_TARGETS;
        tgt_mask   = NUM_TARGETS'(1) << tgt;
        shifted    = {word, beat};
        assembled  = shifted[DATA_WIDTH-1:0];
        word_done  = beat_edge && (beat_cnt == CNT_W'(BEATS - 1));
        granted    = |(mem_request & mem_busy & tgt_mask);
        ready      = |(mem_initialized & ~mem_busy & tgt_mask);
        write_done = ~|(mem_busy & tgt_mask);
        at_top     = &output_address;
        start_ok   = (state == IDLE) && load_start;
        ack_now    = (state == WRITE) && write_done;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (load_start) state_next = tgt_ok ? COLLECT : HALT;
            COLLECT: if (!load) state_next = IDLE;
                     else if (word_done) state_next = REQ;
            REQ:     if (!load) state_next = IDLE;
                     else if (granted) state_next = WRITE;
            WRITE:   if (write_done) state_next = at_top ? HALT : (load ? COLLECT : IDLE);
            HALT:    if (!load) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack            <= 1'b0;
            error          <= 1'b0;
            words_written  <= '0;
            mem_request    <= '0;
            output_data    <= '0;
            output_address <= '0;
            tgt            <= '0;
            beat_cnt       <= '0;
            word           <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: if (load_start) begin
                    tgt            <= target_sel;
                    output_address <= base_address;
                    beat_cnt       <= '0;
                    words_written  <= '0;
                    error          <= ~tgt_ok;
                end
                COLLECT: if (load && beat_edge) begin
                    word <= assembled;
                    if (word_done) begin
                        output_data <= assembled;
                        beat_cnt    <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                REQ: begin
                    if (beat_edge) error <= 1'b1;
                    if (!load || granted) mem_request <= '0;
                    else if (ready)       mem_request <= tgt_mask;
                end
                WRITE: begin
                    if (beat_edge) error <= 1'b1;
                    if (write_done) begin
                        ack            <= 1'b1;
                        output_address <= output_address + 1'b1;
                        words_written  <= words_written + 1'b1;
                        if (at_top) error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || start_ok) checksum <= '0;
        else if (ack_now)      checksum <= checksum + output_data;
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_hack_multi_stream_loader.sv
// Bench for hack_multi_stream_loader: table of fixed sessions, hand-written corner sequences
// and random sessions compared against a word-level reference model.
module tb_hack_multi_stream_loader;
    localparam int DW = 16, IW = 4, AW = 16, NT = 2;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CKS_ON = 1'b1;
`else
    localparam bit CKS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, load, sck, ack, error;
    logic [0:0]    target_sel;
    logic [AW-1:0] base_address, words_written, output_address;
    logic [IW-1:0] input_data;
    logic [NT-1:0] mem_busy = '0;
    logic [NT-1:0] mem_initialized, mem_request;
    logic [DW-1:0] output_data, checksum;

    hack_multi_stream_loader #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .ADDRESS_WIDTH(AW), .NUM_TARGETS(NT)) dut (
        .clk(clk), .reset(reset), .load(load), .target_sel(target_sel),
        .base_address(base_address), .input_data(input_data), .sck(sck), .ack(ack),
        .error(error), .words_written(words_written), .mem_busy(mem_busy),
        .mem_initialized(mem_initialized), .mem_request(mem_request),
        .output_data(output_data), .output_address(output_address), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: grabs a request, holds busy for busy_len cycles, logs the write.
    typedef struct {int t; logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
    wr_t wlog[$];
    int  busy_cnt [NT];
    int  busy_len = 3;
    bit  model_en = 1'b1;
    int  ack_cnt = 0, iso_bad = 0, exp_tgt = 0;

    always @(negedge clk) begin
        if (reset) begin
            mem_busy = '0;
            for (int i = 0; i < NT; i++) busy_cnt[i] = 0;
        end else begin
            if (ack) ack_cnt++;
            if ((mem_request & ~(NT'(1) << exp_tgt)) != '0) iso_bad++;
            for (int i = 0; i < NT; i++) begin
                if (busy_cnt[i] > 0) begin
                    busy_cnt[i]--;
                    if (busy_cnt[i] == 0) mem_busy[i] = 1'b0;
                end else if (mem_request[i] && model_en) begin
                    mem_busy[i] = 1'b1;
                    busy_cnt[i] = busy_len;
                    wlog.push_back('{i, output_address, output_data});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_beat(input logic [IW-1:0] b);
        input_data = b;
        sck = 1'b1;
        tick($urandom_range(3, 5));
        sck = 1'b0;
        tick($urandom_range(3, 5));
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        logic [DW-1:0] v;
        v = w;
        for (int k = 0; k < DW / IW; k++) send_beat(v[DW-1-IW*k -: IW]);
    endtask

    task automatic start(input int t, input logic [AW-1:0] b);
        target_sel   = 1'(t);
        base_address = b;
        exp_tgt      = t;
        load         = 1'b1;
        tick(1);
    endtask

    task automatic wait_acks(input int n, input string name);
        int budget;
        budget = 400;
        while (ack_cnt < n && budget > 0) begin
            tick(1);
            budget--;
        end
        chk({name, " ack arrived"}, 64'(ack_cnt >= n), 64'd1);
    endtask

    task automatic chk_wr(input int idx, input int t, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input string name);
        if (idx < wlog.size()) begin
            chk({name, " wr tgt"},  64'(wlog[idx].t), 64'(t));
            chk({name, " wr addr"}, 64'(wlog[idx].a), 64'(a));
            chk({name, " wr data"}, 64'(wlog[idx].d), 64'(d));
        end else begin
            chk({name, " wr missing"}, 64'(wlog.size()), 64'(idx + 1));
        end
    endtask

    task automatic run_session(input int t, input logic [AW-1:0] b, input int n,
                               input logic [3:0][DW-1:0] w, input string name);
        int a0;
        start(t, b);
        for (int i = 0; i < n; i++) begin
            a0 = ack_cnt;
            send_word(w[i]);
            wait_acks(a0 + 1, name);
        end
        tick(2);
        load = 1'b0;
        tick(3);
    endtask

    task automatic chk_session(input string name, input int t, input logic [AW-1:0] b, input int n,
                               input logic [3:0][DW-1:0] w, input int l0, input logic [AW-1:0] ea,
                               input logic ee, input logic [DW-1:0] ec);
        chk({name, " writes"}, 64'(wlog.size() - l0), 64'(n));
        for (int i = 0; i < n; i++) chk_wr(l0 + i, t, b + AW'(i), w[i], name);
        chk({name, " words_written"}, 64'(words_written), 64'(n));
        chk({name, " address"}, 64'(output_address), 64'(ea));
        chk({name, " error"}, 64'(error), 64'(ee));
        chk({name, " checksum"}, 64'(checksum), CKS_ON ? 64'(ec) : 64'd0);
    endtask

    typedef struct {
        int                  tgt;
        logic [AW-1:0]       base;
        int                  n;
        logic [3:0][DW-1:0]  w;
        logic [AW-1:0]       exp_addr;
        logic                exp_err;
        logic [DW-1:0]       exp_cks;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int l0, a0, bad;
        logic [3:0][DW-1:0] rw;
        logic [AW-1:0] rb;
        logic [DW-1:0] rsum;
        int rt, rn;

        vecs[0] = '{0, 16'h0010, 2, {16'h0, 16'h0, 16'hABCD, 16'h1234}, 16'h0012, 1'b0, 16'hBE01};
        vecs[1] = '{1, 16'h2000, 3, {16'h0, 16'h55AA, 16'hF0F0, 16'h0F0F}, 16'h2003, 1'b0, 16'h55A9};
        vecs[2] = '{0, 16'h0200, 2, {16'h0, 16'h0, 16'h8001, 16'h8000}, 16'h0202, 1'b0, 16'h0001};
        vecs[3] = '{1, 16'hFFFF, 1, {16'h0, 16'h0, 16'h0, 16'hCAFE}, 16'h0000, 1'b1, 16'hCAFE};

        reset = 1'b1; load = 1'b0; sck = 1'b0; input_data = '0;
        target_sel = '0; base_address = '0; mem_initialized = '1;
        tick(3);
        chk("reset ack", 64'(ack), 64'd0);
        chk("reset error", 64'(error), 64'd0);
        chk("reset words_written", 64'(words_written), 64'd0);
        chk("reset mem_request", 64'(mem_request), 64'd0);
        chk("reset output_data", 64'(output_data), 64'd0);
        chk("reset output_address", 64'(output_address), 64'd0);
        chk("reset checksum", 64'(checksum), 64'd0);
        reset = 1'b0;
        tick(2);

        for (int v = 0; v < 4; v++) begin
            l0 = wlog.size();
            run_session(vecs[v].tgt, vecs[v].base, vecs[v].n, vecs[v].w, $sformatf("vec%0d", v));
            chk_session($sformatf("vec%0d", v), vecs[v].tgt, vecs[v].base, vecs[v].n, vecs[v].w, l0,
                        vecs[v].exp_addr, vecs[v].exp_err, vecs[v].exp_cks);
        end

        // Latency: final beat rise sampled at edge N -> request at N+4, not before.
        start(0, 16'h0040);
        send_beat(4'h7); send_beat(4'h8); send_beat(4'h9);
        l0 = wlog.size(); a0 = ack_cnt;
        input_data = 4'hA; sck = 1'b1;
        tick(4);
        chk("latency req before N+4", 64'(mem_request), 64'd0);
        tick(1);
        chk("latency req at N+4", 64'(mem_request), 64'b01);
        sck = 1'b0;
        wait_acks(a0 + 1, "latency");
        chk_wr(l0, 0, 16'h0040, 16'h789A, "latency");
        load = 1'b0; tick(3);

        // Target not initialised: request must wait for init.
        mem_initialized = 2'b01;
        start(1, 16'h0300);
        l0 = wlog.size(); a0 = ack_cnt;
        send_word(16'h4321);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (mem_request != '0) bad++;
        end
        chk("uninit no request", 64'(bad), 64'd0);
        mem_initialized = 2'b11;
        wait_acks(a0 + 1, "uninit");
        chk_wr(l0, 1, 16'h0300, 16'h4321, "uninit");
        load = 1'b0; tick(3);

        // Overrun: extra beat while the write is in progress is dropped and flagged.
        busy_len = 10;
        start(0, 16'h0400);
        l0 = wlog.size(); a0 = ack_cnt;
        send_word(16'h1111);
        bad = 100;
        while (!mem_busy[0] && bad > 0) begin tick(1); bad--; end
        chk("overrun busy seen", 64'(mem_busy[0]), 64'd1);
        send_beat(4'hF);
        wait_acks(a0 + 1, "overrun w0");
        chk("overrun error", 64'(error), 64'd1);
        busy_len = 3;
        send_word(16'h2345);
        wait_acks(a0 + 2, "overrun w1");
        chk_wr(l0, 0, 16'h0400, 16'h1111, "overrun w0");
        chk_wr(l0 + 1, 0, 16'h0401, 16'h2345, "overrun w1");
        load = 1'b0; tick(3);

        // Wrap at 0xFFFF then HALT ignores beats until load drops.
        start(0, 16'hFFFF);
        l0 = wlog.size(); a0 = ack_cnt;
        send_word(16'h1357);
        wait_acks(a0 + 1, "wrap");
        tick(2);
        chk_wr(l0, 0, 16'hFFFF, 16'h1357, "wrap");
        chk("wrap error", 64'(error), 64'd1);
        chk("wrap address", 64'(output_address), 64'd0);
        send_word(16'h2468);
        tick(10);
        chk("halt no write", 64'(wlog.size() - l0), 64'd1);
        chk("halt no ack", 64'(ack_cnt - a0), 64'd1);
        load = 1'b0; tick(3);

        // Partial word discarded on load drop; new session starts clean.
        start(0, 16'h0600);
        send_beat(4'h1); send_beat(4'h2);
        load = 1'b0; tick(5);
        l0 = wlog.size(); a0 = ack_cnt;
        start(0, 16'h0100);
        tick(1);
        chk("reload words_written", 64'(words_written), 64'd0);
        chk("reload error", 64'(error), 64'd0);
        send_word(16'h9ABC);
        wait_acks(a0 + 1, "reload");
        chk("reload writes", 64'(wlog.size() - l0), 64'd1);
        chk_wr(l0, 0, 16'h0100, 16'h9ABC, "reload");
        chk("reload words_written after", 64'(words_written), 64'd1);
        load = 1'b0; tick(3);

        // Reset while a request is outstanding.
        model_en = 1'b0;
        start(0, 16'h0700);
        a0 = ack_cnt;
        send_word(16'h0BAD);
        tick(2);
        chk("pre-reset request", 64'(mem_request), 64'b01);
        reset = 1'b1; load = 1'b0;
        tick(1);
        chk("mid reset request", 64'(mem_request), 64'd0);
        chk("mid reset address", 64'(output_address), 64'd0);
        chk("mid reset data", 64'(output_data), 64'd0);
        reset = 1'b0; model_en = 1'b1;
        tick(3);
        chk("mid reset no ack", 64'(ack_cnt - a0), 64'd0);

        // Random sessions against the word-level reference.
        for (int s = 0; s < 8; s++) begin
            rt = $urandom_range(0, 1);
            rb = AW'($urandom_range(0, 16'hFF00));
            rn = $urandom_range(1, 4);
            busy_len = $urandom_range(1, 5);
            rsum = '0;
            for (int i = 0; i < 4; i++) rw[i] = DW'($urandom);
            for (int i = 0; i < rn; i++) rsum = rsum + rw[i];
            l0 = wlog.size();
            run_session(rt, rb, rn, rw, $sformatf("rand%0d", s));
            chk_session($sformatf("rand%0d", s), rt, rb, rn, rw, l0, rb + AW'(rn),
                        (int'(rb) + rn - 1) >= 65535, rsum);
        end

        chk("target isolation", 64'(iso_bad), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
